div_arbiter: RTL and testbench



---
 rtl/div_arbiter_if.sv | 54 +++++
 rtl/div_arbiter.sv | 139 +++++++++++++
 tb/tb_div_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// div_arbiter_if : request, response and divider-side bundle for div_arbiter
// Revision       : 1.0
// ----------------------------------------------------------------------------
interface div_arbiter_if #(
  parameter int NUM_REQ       = 4,
  parameter int DIVIDEND_BITS = 16,
  parameter int DIVISOR_BITS  = 8,
  parameter int FRAC_BITS     = 8
);
  localparam int ID_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]               req_valid_i;
  logic [NUM_REQ-1:0]               req_ready_o;
  logic [NUM_REQ*DIVIDEND_BITS-1:0] req_dividend_i;
  logic [NUM_REQ*DIVISOR_BITS-1:0]  req_divisor_i;

  logic                             rsp_valid_o;
  logic                             rsp_ready_i;
  logic [ID_BITS-1:0]               rsp_id_o;
  logic [DIVIDEND_BITS-1:0]         rsp_quotient_o;
  logic [FRAC_BITS-1:0]             rsp_frac_o;
  logic                             rsp_dbz_o;

  logic                             div_valid_o;
  logic                             div_ready_i;
  logic [DIVIDEND_BITS-1:0]         div_dividend_o;
  logic [DIVISOR_BITS-1:0]          div_divisor_o;
  logic                             div_valid_i;
  logic [DIVIDEND_BITS-1:0]         div_quotient_i;
  logic [FRAC_BITS-1:0]             div_frac_i;

  // Arbiter side
  modport slave (
    input  req_valid_i, req_dividend_i, req_divisor_i,
    output req_ready_o,
    output rsp_valid_o, rsp_id_o, rsp_quotient_o, rsp_frac_o, rsp_dbz_o,
    input  rsp_ready_i,
    output div_valid_o, div_dividend_o, div_divisor_o,
    input  div_ready_i, div_valid_i, div_quotient_i, div_frac_i
  );

  // Requester / response-consumer / divider side
  modport master (
    output req_valid_i, req_dividend_i, req_divisor_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_id_o, rsp_quotient_o, rsp_frac_o, rsp_dbz_o,
    output rsp_ready_i,
    input  div_valid_o, div_dividend_o, div_divisor_o,
    output div_ready_i, div_valid_i, div_quotient_i, div_frac_i
  );
endinterface
`default_nettype wire

// File: rtl/div_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// div_arbiter : round-robin sharer of one serial divider across NUM_REQ ports
// Revision    : 1.0
// ----------------------------------------------------------------------------
module div_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DIVIDEND_BITS = 16,
  parameter int DIVISOR_BITS  = 8,
  parameter int FRAC_BITS     = 8
) (
  input wire logic     clk_i,
  input wire logic     rst_n_i,
  div_arbiter_if.slave bus
);
  localparam int ID_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                   state;
  logic [ID_BITS-1:0]       last_grant;
  logic [ID_BITS-1:0]       grant_idx;
  logic                     grant_found;
  logic [ID_BITS:0]         cand;
  logic [NUM_REQ-1:0]       req_ready;
  logic [DIVIDEND_BITS-1:0] sel_dividend;
  logic [DIVISOR_BITS-1:0]  sel_divisor;

  logic                     rsp_valid;
  logic [ID_BITS-1:0]       rsp_id;
  logic [DIVIDEND_BITS-1:0] rsp_quotient;
  logic [FRAC_BITS-1:0]     rsp_frac;
  logic                     rsp_dbz;
  logic                     div_valid;
  logic [DIVIDEND_BITS-1:0] div_dividend;
  logic [DIVISOR_BITS-1:0]  div_divisor;

  // Search starts just after the last winner; one extra bit absorbs the wrap
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last_grant} + (ID_BITS+1)'(i);
      if (cand >= (ID_BITS+1)'(NUM_REQ)) begin
        cand = cand - (ID_BITS+1)'(NUM_REQ);
      end
      if (!grant_found && bus.req_valid_i[cand[ID_BITS-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_BITS-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n_i && (state == IDLE) && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign sel_dividend = bus.req_dividend_i[grant_idx*DIVIDEND_BITS +: DIVIDEND_BITS];
  assign sel_divisor  = bus.req_divisor_i[grant_idx*DIVISOR_BITS +: DIVISOR_BITS];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      last_grant   <= ID_BITS'(NUM_REQ-1);
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_quotient <= '0;
      rsp_frac     <= '0;
      rsp_dbz      <= 1'b0;
      div_valid    <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            rsp_id       <= grant_idx;
            last_grant   <= grant_idx;
            div_dividend <= sel_dividend;
            div_divisor  <= sel_divisor;
            // Zero divisor is answered locally and never reaches the divider
            if (sel_divisor == '0) begin
              rsp_quotient <= '1;
              rsp_frac     <= '1;
              rsp_dbz      <= 1'b1;
              rsp_valid    <= 1'b1;
              state        <= RESP;
            end else begin
              div_valid <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (bus.div_ready_i) begin
            div_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (bus.div_valid_i) begin
            rsp_quotient <= bus.div_quotient_i;
            rsp_frac     <= bus.div_frac_i;
            rsp_dbz      <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o    = req_ready;
  assign bus.rsp_valid_o    = rsp_valid;
  assign bus.rsp_id_o       = rsp_id;
  assign bus.rsp_quotient_o = rsp_quotient;
  assign bus.rsp_frac_o     = rsp_frac;
  assign bus.rsp_dbz_o      = rsp_dbz;
  assign bus.div_valid_o    = div_valid;
  assign bus.div_dividend_o = div_dividend;
  assign bus.div_divisor_o  = div_divisor;
endmodule
`default_nettype wire

// File: tb/tb_div_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_div_arbiter : directed + random bench with a transaction-level model
// Revision       : 1.0
// ----------------------------------------------------------------------------
module tb_div_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DB      = 16;
  localparam int SB      = 8;
  localparam int FB      = 8;
  localparam int DIV_LAT = 3;

  typedef struct {
    int          id;
    logic [DB-1:0] a;
    logic [SB-1:0] b;
    logic [DB-1:0] q;
    logic [FB-1:0] f;
    logic          dbz;
  } item_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  div_arbiter_if #(.NUM_REQ(NUM_REQ), .DIVIDEND_BITS(DB), .DIVISOR_BITS(SB), .FRAC_BITS(FB)) bus ();

  div_arbiter #(.NUM_REQ(NUM_REQ), .DIVIDEND_BITS(DB), .DIVISOR_BITS(SB), .FRAC_BITS(FB)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  // Serial divider stand-in; not reset by rst_n, like a separate block
  logic          div_busy     = 1'b0;
  logic          model_pulse  = 1'b0;
  logic          force_busy   = 1'b0;
  logic          inject_stale = 1'b0;
  logic          hs_q         = 1'b0;
  int            div_cnt      = 0;
  logic [DB-1:0] m_a = '0;
  logic [SB-1:0] m_b = '0;
  logic [DB-1:0] m_q = '0;
  logic [FB-1:0] m_f = '0;

  assign bus.div_ready_i    = !div_busy && !force_busy;
  assign bus.div_valid_i    = model_pulse || inject_stale;
  assign bus.div_quotient_i = m_q;
  assign bus.div_frac_i     = m_f;

  always @(posedge clk) hs_q <= bus.div_valid_o && bus.div_ready_i;

  always @(negedge clk) begin
    model_pulse = 1'b0;
    if (hs_q) begin
      div_busy = 1'b1;
      div_cnt  = DIV_LAT;
      m_a      = bus.div_dividend_o;
      m_b      = bus.div_divisor_o;
    end else if (div_busy) begin
      div_cnt = div_cnt - 1;
      if (div_cnt == 0) begin
        div_busy    = 1'b0;
        model_pulse = 1'b1;
        if (m_b == '0) begin
          m_q = '1;
          m_f = '1;
        end else begin
          m_q = DB'(32'(m_a) / 32'(m_b));
          m_f = FB'(((32'(m_a) % 32'(m_b)) << FB) / 32'(m_b));
        end
      end
    end
  end

  // Stimulus for the next cycle, applied inside step()
  logic [NUM_REQ-1:0] nv;
  logic [DB-1:0]      nd [NUM_REQ];
  logic [SB-1:0]      ns [NUM_REQ];
  logic               n_rst, n_rsp_ready, n_force, n_inject;
  logic               refill;

  // Reference model state
  item_t exp_q [$];
  int    rsp_ids [$];
  int    m_last;
  logic  busy, exp_issue, waiting, exp_rsp;
  int    dut_acc;
  int    tests = 0;
  int    fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
    int c;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = (last + k) % NUM_REQ;
      if (v[c] === 1'b1) return c;
    end
    return -1;
  endfunction

  function automatic item_t make_item(input int id, input logic [DB-1:0] a, input logic [SB-1:0] b);
    item_t it;
    logic [31:0] ua, ub;
    it.id = id;
    it.a  = a;
    it.b  = b;
    ua    = 32'(a);
    ub    = 32'(b);
    if (b == '0) begin
      it.q   = '1;
      it.f   = '1;
      it.dbz = 1'b1;
    end else begin
      it.q   = DB'(ua / ub);
      it.f   = FB'(((ua % ub) * (32'd1 << FB)) / ub);
      it.dbz = 1'b0;
    end
    return it;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_last    = NUM_REQ - 1;
    busy      = 1'b0;
    exp_issue = 1'b0;
    waiting   = 1'b0;
    exp_rsp   = 1'b0;
  endtask

  task automatic check_and_model();
    int g;
    logic [NUM_REQ-1:0] er;
    logic acc, hs, res, cons;
    item_t it;
    g  = rr_pick(bus.req_valid_i, m_last);
    er = '0;
    if (rst_n && !busy && g >= 0) er[g] = 1'b1;
    chk("req_ready", 32'(bus.req_ready_o), 32'(er));
    chk("div_valid", 32'(bus.div_valid_o), 32'(exp_issue));
    if (exp_issue && exp_q.size() > 0) begin
      chk("div_dividend", 32'(bus.div_dividend_o), 32'(exp_q[0].a));
      chk("div_divisor", 32'(bus.div_divisor_o), 32'(exp_q[0].b));
    end
    chk("rsp_valid", 32'(bus.rsp_valid_o), 32'(exp_rsp));
    if (exp_rsp && exp_q.size() > 0) begin
      chk("rsp_id", 32'(bus.rsp_id_o), 32'(exp_q[0].id));
      chk("rsp_quotient", 32'(bus.rsp_quotient_o), 32'(exp_q[0].q));
      chk("rsp_frac", 32'(bus.rsp_frac_o), 32'(exp_q[0].f));
      chk("rsp_dbz", 32'(bus.rsp_dbz_o), 32'(exp_q[0].dbz));
    end
    if (bus.req_ready_o !== '0) dut_acc++;
    if (!rst_n) begin
      model_reset();
    end else begin
      acc  = (er != '0);
      hs   = exp_issue && (bus.div_ready_i === 1'b1);
      res  = waiting && (bus.div_valid_i === 1'b1);
      cons = exp_rsp && (bus.rsp_ready_i === 1'b1);
      if (cons) begin
        rsp_ids.push_back(int'(bus.rsp_id_o));
        it      = exp_q.pop_front();
        exp_rsp = 1'b0;
        busy    = 1'b0;
      end
      if (hs) begin
        exp_issue = 1'b0;
        waiting   = 1'b1;
      end
      if (res) begin
        waiting = 1'b0;
        exp_rsp = 1'b1;
      end
      if (acc) begin
        it = make_item(g, bus.req_dividend_i[g*DB +: DB], bus.req_divisor_i[g*SB +: SB]);
        exp_q.push_back(it);
        busy   = 1'b1;
        m_last = g;
        if (it.dbz) exp_rsp = 1'b1;
        else        exp_issue = 1'b1;
        if (refill) begin
          nd[g] = DB'($urandom);
          ns[g] = SB'($urandom_range(1, 255));
        end else begin
          nv[g] = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    rst_n           = n_rst;
    force_busy      = n_force;
    inject_stale    = n_inject;
    bus.rsp_ready_i = n_rsp_ready;
    bus.req_valid_i = nv;
    for (int k = 0; k < NUM_REQ; k++) begin
      bus.req_dividend_i[k*DB +: DB] = nd[k];
      bus.req_divisor_i[k*SB +: SB]  = ns[k];
    end
    #1;
    check_and_model();
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (bus.rsp_valid_o !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    chk({tag, "_rsp_seen"}, 32'(bus.rsp_valid_o), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    nv          = '0;
    n_rsp_ready = 1'b1;
    n_force     = 1'b0;
    n_inject    = 1'b0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    step();
    chk("drain_idle", 32'({bus.rsp_valid_o, bus.div_valid_o}), 32'd0);
  endtask

  task automatic rand_ops();
    for (int k = 0; k < NUM_REQ; k++) begin
      nd[k] = DB'($urandom);
      ns[k] = ($urandom_range(0, 7) == 0) ? '0 : SB'($urandom_range(1, 255));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DB-1:0] a;
    logic [SB-1:0] b;
    int a0;
    rst_n              = 1'b0;
    bus.req_valid_i    = '0;
    bus.req_dividend_i = '0;
    bus.req_divisor_i  = '0;
    bus.rsp_ready_i    = 1'b0;
    nv = '0; n_rst = 1'b0; n_rsp_ready = 1'b0; n_force = 1'b0; n_inject = 1'b0; refill = 1'b0;
    dut_acc = 0;
    for (int k = 0; k < NUM_REQ; k++) begin nd[k] = '0; ns[k] = '0; end
    model_reset();
    repeat (2) @(posedge clk);

    // Reset values
    step();
    chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("rst_div_valid", 32'(bus.div_valid_o), 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id_o), 32'd0);
    chk("rst_quotient", 32'(bus.rsp_quotient_o), 32'd0);
    chk("rst_frac", 32'(bus.rsp_frac_o), 32'd0);
    chk("rst_dbz", 32'(bus.rsp_dbz_o), 32'd0);
    chk("rst_div_dividend", 32'(bus.div_dividend_o), 32'd0);
    chk("rst_div_divisor", 32'(bus.div_divisor_o), 32'd0);
    n_rst = 1'b1;

    // Single request: 100 / 7 from requester 2
    nd[2] = 16'd100; ns[2] = 8'd7; nv = 4'b0100; n_rsp_ready = 1'b1;
    wait_rsp("single");
    chk("single_id", 32'(bus.rsp_id_o), 32'd2);
    chk("single_q", 32'(bus.rsp_quotient_o), 32'd14);
    chk("single_f", 32'(bus.rsp_frac_o), 32'h49);
    chk("single_dbz", 32'(bus.rsp_dbz_o), 32'd0);
    drain();

    // Round robin from a fresh reset
    n_rst = 1'b0; step(); n_rst = 1'b1;
    rsp_ids.delete();
    refill = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      nd[k] = DB'($urandom);
      ns[k] = SB'($urandom_range(1, 255));
    end
    nv = '1;
    for (int n = 0; n < 200 && rsp_ids.size() < 5; n++) step();
    refill = 1'b0;
    chk("rr_count", 32'(rsp_ids.size() >= 5), 32'd1);
    for (int k = 0; k < 5 && k < rsp_ids.size(); k++) begin
      chk($sformatf("rr_order%0d", k), 32'(rsp_ids[k]), 32'(k % NUM_REQ));
    end
    drain();

    // Divide by zero
    nd[1] = 16'd500; ns[1] = 8'd0; nv = 4'b0010;
    step();
    step();
    chk("dbz_next_cycle", 32'(bus.rsp_valid_o), 32'd1);
    chk("dbz_id", 32'(bus.rsp_id_o), 32'd1);
    chk("dbz_q", 32'(bus.rsp_quotient_o), 32'hFFFF);
    chk("dbz_f", 32'(bus.rsp_frac_o), 32'hFF);
    chk("dbz_flag", 32'(bus.rsp_dbz_o), 32'd1);
    drain();

    // Backpressure
    n_rsp_ready = 1'b0;
    nd[3] = DB'($urandom); ns[3] = SB'($urandom_range(1, 255)); nv = 4'b1000;
    wait_rsp("bp");
    rand_ops(); ns[0] = 8'd3; ns[1] = 8'd5; ns[2] = 8'd9; nv = 4'b0111;
    repeat (10) step();
    chk("bp_hold_valid", 32'(bus.rsp_valid_o), 32'd1);
    chk("bp_hold_id", 32'(bus.rsp_id_o), 32'd3);
    a0 = dut_acc;
    n_rsp_ready = 1'b1;
    repeat (3) step();
    chk("bp_one_accept", 32'(dut_acc - a0), 32'd1);
    drain();

    // Busy divider holds ISSUE
    a = DB'($urandom); b = SB'($urandom_range(1, 255));
    n_force = 1'b1; nd[0] = a; ns[0] = b; nv = 4'b0001;
    step();
    repeat (5) step();
    chk("busy_hold_valid", 32'(bus.div_valid_o), 32'd1);
    chk("busy_hold_dividend", 32'(bus.div_dividend_o), 32'(a));
    n_force = 1'b0;
    wait_rsp("busy");
    chk("busy_q", 32'(bus.rsp_quotient_o), 32'(a) / 32'(b));
    drain();

    // Reset while waiting for the divider
    nd[2] = 16'd1234; ns[2] = 8'd10; nv = 4'b0100;
    for (int n = 0; n < 10 && !waiting; n++) step();
    chk("midwait_reached", 32'(waiting), 32'd1);
    n_rst = 1'b0; step(); n_rst = 1'b1;
    n_force = 1'b1; step();
    n_inject = 1'b1; step();
    n_inject = 1'b0; step();
    chk("stale_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
    a = 16'd40000; b = 8'd3;
    nd[1] = a; ns[1] = b; nv = 4'b0010;
    step(); step();
    n_force = 1'b0;
    wait_rsp("after_reset");
    chk("after_reset_id", 32'(bus.rsp_id_o), 32'd1);
    chk("after_reset_q", 32'(bus.rsp_quotient_o), 32'd13333);
    chk("after_reset_f", 32'(bus.rsp_frac_o), 32'd85);
    drain();

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      rand_ops();
      nv          = NUM_REQ'($urandom);
      n_rsp_ready = ($urandom_range(0, 3) != 0);
      n_force     = ($urandom_range(0, 5) == 0);
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
